frv_lfsr_prng: RTL and testbench
================================

FRV_LFSR_PRNG -- requirements
Module: frv_lfsr_prng

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning state/output width in bits; legal range 8..64.
REQ-002 SHALL have parameter TAPS, default 32'h80200003, meaning a WIDTH-bit feedback tap mask (bits 31, 21, 1, 0).
REQ-003 SHALL have parameter RESET_VALUE, default 32'h6789ABCD, meaning the WIDTH-bit reset/recovery state; SHALL NOT be all-ones.
REQ-004 SHALL have parameter STEPS, default 1, meaning LFSR shifts per update; legal range 1..8.
REQ-005 SHALL have parameter WARMUP, default 16, meaning autonomous shifts after reseed; legal range 1..255.
REQ-006 SHALL have port g_clk input 1, the clock.
REQ-007 SHALL have port g_resetn input 1, reset that is synchronous and active-low.
REQ-008 SHALL have port update input 1, which advances the PRNG by STEPS shifts.
REQ-009 SHALL have port extra_tap input STEPS, holding entropy bits, with bit i mixed into shift i.
REQ-010 SHALL have port seed_valid input 1, a reseed request.
REQ-011 SHALL have port seed_data input WIDTH, the reseed value.
REQ-012 SHALL have port seed_ready output 1, meaning a reseed can be accepted.
REQ-013 SHALL have port prng output WIDTH, the current registered state.
REQ-014 SHALL have port n_prng output WIDTH, the combinational state after STEPS shifts.
REQ-015 SHALL have port prng_valid output 1, meaning prng is usable (not warming up).
REQ-016 SHALL have port lockup_err output 1, a sticky lockup/illegal-seed flag.

Function
REQ-017 SHALL define one shift on state s with entropy bit e as: fb = NOT(XOR-reduce(s AND TAPS)) XOR e; s' = {s[WIDTH-2:0], fb}.
REQ-018 SHALL compute n_prng as STEPS chained shifts of prng, in order extra_tap[0] first through extra_tap[STEPS-1] last, purely combinationally.
REQ-019 SHALL implement an FSM with states RUN and WARM.
REQ-020 SHALL drive seed_ready=1 and prng_valid=1 in RUN, and seed_ready=0 and prng_valid=0 in WARM.
REQ-021 In RUN, when seed_valid and seed_ready are both 1 (accept), SHALL on that edge load prng<=seed_data, set the warm counter to WARMUP, and enter WARM.
REQ-022 When a seed is accepted and seed_data is all-ones, SHALL load RESET_VALUE instead and set lockup_err=1.
REQ-023 In RUN, without accept, when update=1, SHALL set prng<=n_prng; when update=0, SHALL hold prng.
REQ-024 When seed accept and update coincide, SHALL give the seed priority and ignore update for that cycle.
REQ-025 In WARM, SHALL set prng<=n_prng every cycle regardless of update, using the live extra_tap, and decrement the counter.
REQ-026 In WARM, SHALL ignore update and seed_valid.
REQ-027 SHALL leave WARM for RUN on the edge where the counter goes 1->0, so that prng_valid rises exactly WARMUP cycles after the accept edge.
REQ-028 In RUN, when prng is all-ones at an edge without accept, SHALL load prng<=RESET_VALUE and set lockup_err=1, regardless of update.
REQ-029 SHALL clear lockup_err on an accepted seed whose seed_data is not all-ones; otherwise lockup_err SHALL remain sticky.
REQ-030 SHALL size the warm counter as $clog2(WARMUP+1) bits, with no wrap-around past 0.

Reset
REQ-031 On g_resetn=0 at a g_clk edge, SHALL set prng=RESET_VALUE, FSM=RUN, counter=0, lockup_err=0, seed_ready=1, prng_valid=1.
REQ-032 Reset asserted during WARM SHALL abort warm-up and take priority over seed, update and lockup recovery.

Verification
REQ-033 SHALL cover: defaults, reset, then update=1 with extra_tap=0 -> prng=0xCF13579A after one edge; same with extra_tap=1 -> 0xCF13579B.
REQ-034 SHALL cover: seed_valid=1 with seed_data=0x00000001 in RUN -> prng=0x00000001, seed_ready=0 and prng_valid=0 for 16 cycles, then prng_valid=1, with update ignored throughout.
REQ-035 SHALL cover: seed_data=0xFFFFFFFF -> prng=0x6789ABCD and lockup_err=1; a later seed of 0x12345678 -> lockup_err=0.
REQ-036 SHALL cover: forcing an all-ones state via the extra_tap sequence in RUN -> next edge prng=0x6789ABCD and lockup_err=1.
REQ-037 SHALL cover: seed_valid and update asserted together -> prng equals seed_data, not n_prng.
REQ-038 SHALL cover: STEPS=4, WIDTH=64 build -> n_prng matches a four-fold application of REQ-017 against a reference model over 10k random updates, and reset asserted mid-WARM restores RESET_VALUE with prng_valid=1.

Source files
------------

// File: rtl/frv_lfsr_prng.sv
// Fibonacci-style LFSR PRNG with optional entropy injection, reseed handshake,
// post-reseed warm-up and all-ones lockup recovery.

module frv_lfsr_prng_step #(
    parameter int               WIDTH = 32,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(32'h80200003)
) (
    input  logic [WIDTH-1:0] s,
    input  logic             e,
    output logic [WIDTH-1:0] s_n
);
    // Inverted parity keeps all-zeros in the sequence; all-ones becomes the stuck state.
    assign s_n = {s[WIDTH-2:0], ~(^(s & TAPS)) ^ e};
endmodule

module frv_lfsr_prng #(
    parameter int               WIDTH       = 32,
    parameter logic [WIDTH-1:0] TAPS        = WIDTH'(32'h80200003),
    parameter logic [WIDTH-1:0] RESET_VALUE = WIDTH'(32'h6789ABCD),
    parameter int               STEPS       = 1,
    parameter int               WARMUP      = 16
) (
    input  logic             g_clk,
    input  logic             g_resetn,
    input  logic             update,
    input  logic [STEPS-1:0] extra_tap,
    input  logic             seed_valid,
    input  logic [WIDTH-1:0] seed_data,
    output logic             seed_ready,
    output logic [WIDTH-1:0] prng,
    output logic [WIDTH-1:0] n_prng,
    output logic             prng_valid,
    output logic             lockup_err
);
    localparam int CW = $clog2(WARMUP + 1);

    typedef enum logic {RUN, WARM} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] prng_q,  prng_d;
    logic [CW-1:0]    cnt_q,   cnt_d;
    logic             lock_q,  lock_d;

    logic [STEPS:0][WIDTH-1:0] chain;

    assign chain[0] = prng_q;

    // extra_tap[0] feeds the first shift, so chain order matches bit order.
    for (genvar g = 0; g < STEPS; g++) begin : g_step
        frv_lfsr_prng_step #(
            .WIDTH (WIDTH),
            .TAPS  (TAPS)
        ) u_step (
            .s   (chain[g]),
            .e   (extra_tap[g]),
            .s_n (chain[g+1])
        );
    end

    assign n_prng     = chain[STEPS];
    assign prng       = prng_q;
    assign lockup_err = lock_q;

    always_comb begin
        state_d    = state_q;
        prng_d     = prng_q;
        cnt_d      = cnt_q;
        lock_d     = lock_q;
        seed_ready = (state_q == RUN);
        prng_valid = (state_q == RUN);
        case (state_q)
            RUN: begin
                if (seed_valid && seed_ready) begin
                    state_d = WARM;
                    cnt_d   = CW'(WARMUP);
                    if (&seed_data) begin
                        prng_d = RESET_VALUE;
                        lock_d = 1'b1;
                    end else begin
                        prng_d = seed_data;
                        lock_d = 1'b0;
                    end
                end else if (&prng_q) begin
                    prng_d = RESET_VALUE;
                    lock_d = 1'b1;
                end else if (update) begin
                    prng_d = n_prng;
                end
            end
            WARM: begin
                prng_d = n_prng;
                if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
                // Counter at 0 here is unreachable; leaving anyway avoids a hang.
                if (cnt_q <= CW'(1)) state_d = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            state_q <= RUN;
            prng_q  <= RESET_VALUE;
            cnt_q   <= '0;
            lock_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            prng_q  <= prng_d;
            cnt_q   <= cnt_d;
            lock_q  <= lock_d;
        end
    end
endmodule

// File: tb/tb_frv_lfsr_prng.sv
// Bench for frv_lfsr_prng: default 32-bit build plus a 64-bit, 4-step build,
// each tracked by a behavioural model of the shift rule and reseed/warm-up flow.

module tb_frv_lfsr_prng;
    localparam logic [63:0] TAPS_A = 64'h0000_0000_8020_0003;
    localparam logic [63:0] RV_A   = 64'h0000_0000_6789_ABCD;
    localparam int          WARM_A = 16;
    localparam logic [63:0] TAPS_B = 64'hD800_0000_0000_0000;
    localparam logic [63:0] RV_B   = 64'h0123_4567_89AB_CDEF;
    localparam int          WARM_B = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn_a, upd_a, sv_a, sr_a, pv_a, le_a;
    logic [0:0]  et_a;
    logic [31:0] sd_a, prng_a, nprng_a;

    logic        rstn_b, upd_b, sv_b, sr_b, pv_b, le_b;
    logic [3:0]  et_b;
    logic [63:0] sd_b, prng_b, nprng_b;

    frv_lfsr_prng u_dut_a (
        .g_clk      (clk),
        .g_resetn   (rstn_a),
        .update     (upd_a),
        .extra_tap  (et_a),
        .seed_valid (sv_a),
        .seed_data  (sd_a),
        .seed_ready (sr_a),
        .prng       (prng_a),
        .n_prng     (nprng_a),
        .prng_valid (pv_a),
        .lockup_err (le_a)
    );

    frv_lfsr_prng #(
        .WIDTH       (64),
        .TAPS        (TAPS_B),
        .RESET_VALUE (RV_B),
        .STEPS       (4),
        .WARMUP      (WARM_B)
    ) u_dut_b (
        .g_clk      (clk),
        .g_resetn   (rstn_b),
        .update     (upd_b),
        .extra_tap  (et_b),
        .seed_valid (sv_b),
        .seed_data  (sd_b),
        .seed_ready (sr_b),
        .prng       (prng_b),
        .n_prng     (nprng_b),
        .prng_valid (pv_b),
        .lockup_err (le_b)
    );

    int errors = 0;
    int checks = 0;

    logic [31:0] ma_s;
    bit          ma_lock;
    int          ma_warm;
    logic [63:0] mb_s;
    bit          mb_lock;
    int          mb_warm;

    // One shift: count tapped ones, feedback is 1 when that count is even, then XOR entropy.
    function automatic logic [63:0] shift1(logic [63:0] s, logic e, logic [63:0] taps, int w);
        int          ones = 0;
        logic [63:0] r;
        for (int i = 0; i < w; i++) if (s[i] && taps[i]) ones++;
        r = (s << 1) | 64'((ones % 2 == 0) ^ e);
        if (w < 64) r = r & ((64'd1 << w) - 64'd1);
        return r;
    endfunction

    function automatic logic [63:0] shiftn(logic [63:0] s, logic [7:0] et, int steps,
                                           logic [63:0] taps, int w);
        logic [63:0] r = s;
        for (int i = 0; i < steps; i++) r = shift1(r, et[i], taps, w);
        return r;
    endfunction

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step_a();
        if (!rstn_a) begin
            ma_s = RV_A[31:0]; ma_warm = 0; ma_lock = 0;
        end else if (ma_warm > 0) begin
            ma_s = 32'(shiftn(64'(ma_s), 8'(et_a), 1, TAPS_A, 32));
            ma_warm--;
        end else if (sv_a) begin
            if (sd_a == 32'hFFFF_FFFF) begin ma_s = RV_A[31:0]; ma_lock = 1; end
            else begin ma_s = sd_a; ma_lock = 0; end
            ma_warm = WARM_A;
        end else if (ma_s == 32'hFFFF_FFFF) begin
            ma_s = RV_A[31:0]; ma_lock = 1;
        end else if (upd_a) begin
            ma_s = 32'(shiftn(64'(ma_s), 8'(et_a), 1, TAPS_A, 32));
        end
    endtask

    task automatic step_b();
        if (!rstn_b) begin
            mb_s = RV_B; mb_warm = 0; mb_lock = 0;
        end else if (mb_warm > 0) begin
            mb_s = shiftn(mb_s, 8'(et_b), 4, TAPS_B, 64);
            mb_warm--;
        end else if (sv_b) begin
            if (sd_b == '1) begin mb_s = RV_B; mb_lock = 1; end
            else begin mb_s = sd_b; mb_lock = 0; end
            mb_warm = WARM_B;
        end else if (mb_s == '1) begin
            mb_s = RV_B; mb_lock = 1;
        end else if (upd_b) begin
            mb_s = shiftn(mb_s, 8'(et_b), 4, TAPS_B, 64);
        end
    endtask

    task automatic check_models();
        chk("a_prng",   64'(prng_a),  64'(ma_s));
        chk("a_nprng",  64'(nprng_a), shiftn(64'(ma_s), 8'(et_a), 1, TAPS_A, 32));
        chk("a_valid",  64'(pv_a),    64'(ma_warm == 0));
        chk("a_ready",  64'(sr_a),    64'(ma_warm == 0));
        chk("a_lockup", 64'(le_a),    64'(ma_lock));
        chk("b_prng",   prng_b,       mb_s);
        chk("b_nprng",  nprng_b,      shiftn(mb_s, 8'(et_b), 4, TAPS_B, 64));
        chk("b_valid",  64'(pv_b),    64'(mb_warm == 0));
        chk("b_ready",  64'(sr_b),    64'(mb_warm == 0));
        chk("b_lockup", 64'(le_b),    64'(mb_lock));
    endtask

    task automatic tick();
        step_a();
        step_b();
        @(posedge clk);
        #1;
        check_models();
    endtask

    initial begin
        rstn_a = 0; upd_a = 0; et_a = 0; sv_a = 0; sd_a = 0;
        rstn_b = 0; upd_b = 0; et_b = 0; sv_b = 0; sd_b = 0;
        tick();
        chk("rst_prng",   64'(prng_a), 64'h6789ABCD);
        chk("rst_valid",  64'(pv_a),   64'd1);
        chk("rst_ready",  64'(sr_a),   64'd1);
        chk("rst_lockup", 64'(le_a),   64'd0);
        chk("rst_b_prng", prng_b,      RV_B);

        // Single update from reset, without and with entropy.
        rstn_a = 1; rstn_b = 1; upd_a = 1; et_a = 0;
        tick();
        chk("upd_e0", 64'(prng_a), 64'hCF13579A);
        rstn_a = 0;
        tick();
        rstn_a = 1; et_a = 1;
        tick();
        chk("upd_e1", 64'(prng_a), 64'hCF13579B);

        // Reseed, then warm-up with update/seed_valid toggling underneath.
        upd_a = 0; sv_a = 1; sd_a = 32'h0000_0001;
        tick();
        chk("seed_prng",  64'(prng_a), 64'h1);
        chk("seed_ready", 64'(sr_a),   64'd0);
        chk("seed_valid", 64'(pv_a),   64'd0);
        for (int i = 0; i < 15; i++) begin
            sv_a = 1'($urandom); sd_a = $urandom; upd_a = 1'($urandom); et_a = 1'($urandom);
            tick();
            chk("warm_valid_low", 64'(pv_a), 64'd0);
        end
        sv_a = 1; upd_a = 1;
        tick();
        chk("warm_done", 64'(pv_a), 64'd1);
        sv_a = 0; upd_a = 0; et_a = 0;

        // All-ones seed maps to RESET_VALUE and flags; a clean seed clears the flag.
        sv_a = 1; sd_a = 32'hFFFF_FFFF;
        tick();
        chk("ones_seed_prng", 64'(prng_a), 64'h6789ABCD);
        chk("ones_seed_lock", 64'(le_a),   64'd1);
        sv_a = 0;
        repeat (WARM_A) tick();
        sv_a = 1; sd_a = 32'h1234_5678;
        tick();
        chk("clean_seed_prng", 64'(prng_a), 64'h12345678);
        chk("clean_seed_lock", 64'(le_a),   64'd0);
        sv_a = 0;
        repeat (WARM_A) tick();

        // Drive feedback to 1 on every shift until the state is all-ones.
        upd_a = 1;
        for (int i = 0; i < 32; i++) begin
            et_a = ^(ma_s & TAPS_A[31:0]);
            tick();
        end
        chk("forced_ones", 64'(prng_a), 64'hFFFF_FFFF);
        upd_a = 0; et_a = 0;
        tick();
        chk("lockup_prng", 64'(prng_a), 64'h6789ABCD);
        chk("lockup_flag", 64'(le_a),   64'd1);

        // Seed wins over a coincident update.
        sv_a = 1; upd_a = 1; sd_a = $urandom & 32'h7FFF_FFFF;
        tick();
        chk("seed_priority", 64'(prng_a), 64'(sd_a));
        sv_a = 0; upd_a = 0;
        repeat (WARM_A) tick();

        // Randomised run of both builds against the models.
        upd_b = 1;
        for (int i = 0; i < 10000; i++) begin
            upd_a = 1'($urandom);
            et_a  = 1'($urandom);
            sv_a  = ($urandom_range(0, 63) == 0);
            sd_a  = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
            et_b  = 4'($urandom_range(0, 15));
            sv_b  = ($urandom_range(0, 255) == 0);
            sd_b  = ($urandom_range(0, 7) == 0) ? '1 : {$urandom, $urandom};
            tick();
        end

        // Reset in the middle of warm-up on the wide build.
        upd_a = 0; sv_a = 0;
        sv_b = 1; sd_b = 64'hA5A5_0000_1234_5678;
        tick();
        sv_b = 0;
        tick();
        chk("b_midwarm_valid", 64'(pv_b), 64'd0);
        rstn_b = 0;
        tick();
        chk("b_rst_prng",   prng_b,      RV_B);
        chk("b_rst_valid",  64'(pv_b),   64'd1);
        chk("b_rst_ready",  64'(sr_b),   64'd1);
        chk("b_rst_lockup", 64'(le_b),   64'd0);
        rstn_b = 1;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
